branch_pc_sequencer: RTL and testbench
======================================

Name: branch_pc_sequencer

Overview:
Fetch-stage controller that owns the program counter and sequences conditional branches for the processor pipeline.
- Consumes the branch-taken bit produced by the branch-condition evaluator, plus the decoded branch target.
- Holds fetch while the flags a branch depends on are still being written.
- Redirects the PC on a taken branch and asserts a flush of wrong-path instructions.

Parameters:
ADDR_WIDTH, 10, width of PC and branch target
RESET_PC, 0, PC value loaded on reset
FLUSH_CYCLES, 2, cycles oFlush stays high after a redirect (legal range 1..15)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
iStall  input  1  pipeline stall; freezes the block
iBranchValid  input  1  a branch instruction is in decode this cycle
iBranchTaken  input  1  taken bit from the branch-condition evaluator (valid with current flags)
iBranchTarget  input  ADDR_WIDTH  absolute target of the branch in decode
iFlagsBusy  input  1  an in-flight instruction will still write N/Z/C of A or B
oPC  output  ADDR_WIDTH  fetch address
oFetchValid  output  1  oPC is a valid fetch this cycle
oFlush  output  1  squash fetch/decode wrong-path instructions
oBranchPending  output  1  a branch is waiting on flags

Behaviour:
- Reset (synchronous, highest priority, including mid-wait or mid-flush):
  - oPC=RESET_PC, state=RUN, oFetchValid=1 from the first cycle after reset, oFlush=0, oBranchPending=0, flush counter=0, latched target=0.
- All outputs are registered. Decisions are made in cycle T and visible in T+1.
- iStall=1 (when not in reset): state, PC, latched target and flush counter all hold; no branch is evaluated; outputs keep their values.
- States: RUN, WAIT_FLAGS, FLUSH.
- RUN:
  - No branch: PC<=PC+1 (modulo 2^ADDR_WIDTH; max value wraps to 0), oFetchValid=1.
  - iBranchValid & iFlagsBusy: latch iBranchTarget; PC holds; oFetchValid<=0; oBranchPending<=1; go WAIT_FLAGS.
  - iBranchValid & !iFlagsBusy & iBranchTaken: PC<=iBranchTarget; oFlush<=1; counter<=FLUSH_CYCLES; go FLUSH.
  - iBranchValid & !iFlagsBusy & !iBranchTaken: treated as no branch (PC+1).
- WAIT_FLAGS:
  - iBranchValid and iBranchTarget are ignored; decode holds the branch, and the latched target is used.
  - iFlagsBusy=1: stay; PC holds; oFetchValid=0.
  - iFlagsBusy=0, taken: PC<=latched target; oFlush<=1; counter<=FLUSH_CYCLES; oBranchPending<=0; go FLUSH.
  - iFlagsBusy=0, not taken: PC<=PC+1; oFetchValid<=1; oBranchPending<=0; go RUN.
- FLUSH:
  - oFlush=1 and oFetchValid=1; fetch proceeds from the target, PC<=PC+1 each cycle.
  - iBranchValid is ignored because it belongs to a wrong-path instruction.
  - Counter decrements each unstalled cycle. When the counter is 1, next cycle oFlush<=0 and go RUN.
  - Net result: oFlush is high for exactly FLUSH_CYCLES unstalled cycles.
- The target is used unmodified (absolute address); bits above ADDR_WIDTH do not exist.
- iBranchTaken is sampled only in RUN with iBranchValid, or in WAIT_FLAGS with !iFlagsBusy; all other values are don't-care.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: adds outputs oBranchCount[15:0] and oTakenCount[15:0], both reset to 0 and saturating at 0xFFFF.
  - oBranchCount increments once per resolved branch (taken or not), in the resolving cycle.
  - oTakenCount increments once per taken branch.
  - Stalled cycles and ignored branches (FLUSH, WAIT_FLAGS re-presentation) do not count.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0x010, then release, no branches, 5 cycles -> oPC 0x010,0x011,...,0x014; oFetchValid=1; oFlush=0.
2. oPC=0x3FF, no branch -> next oPC=0x000 (wrap); oFetchValid stays 1.
3. RUN, iBranchValid=1, iBranchTaken=1, target=0x120, iFlagsBusy=0, FLUSH_CYCLES=2 -> next oPC=0x120; oFlush=1 for exactly 2 cycles (oPC 0x120,0x121); state RUN with oPC=0x122.
4. iBranchValid=1, iFlagsBusy=1 for 3 cycles, target=0x050, then busy drops with iBranchTaken=1 -> oBranchPending=1 and oFetchValid=0 for 3 cycles with PC held; then oPC=0x050 and oFlush=1. Repeat with iBranchTaken=0 -> oPC=held+1, no flush.
5. In FLUSH, iStall=1 for 2 cycles, and in the first FLUSH cycle iBranchValid=1, iBranchTaken=1, target=0x3AA -> PC and counter frozen during stall; the branch is ignored; oFlush total unstalled high cycles = FLUSH_CYCLES.
6. Reset asserted during WAIT_FLAGS and, separately, during FLUSH -> next cycle oPC=RESET_PC, oFlush=0, oBranchPending=0; with BRANCH_STATS_EN, counters=0, and 3 taken + 2 not-taken branches afterwards -> oBranchCount=5, oTakenCount=3.

Source files
------------

// File: rtl/branch_pc_sequencer.sv
// Fetch-stage PC owner: sequences conditional branches, waits on in-flight flag writes, flushes on redirect.
// Optional BRANCH_STATS_EN adds saturating resolved/taken branch counters.
module branch_pc_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int RESET_PC     = 0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStall,
  input  logic                  iBranchValid,
  input  logic                  iBranchTaken,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  input  logic                  iFlagsBusy,
  output logic [ADDR_WIDTH-1:0] oPC,
  output logic                  oFetchValid,
  output logic                  oFlush,
  output logic                  oBranchPending
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]           oBranchCount,
  output logic [15:0]           oTakenCount
`endif
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ONE    = 1;
  localparam logic [3:0]            FC     = FLUSH_CYCLES[3:0];

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, r_tgt, w_pc, w_tgt;
  logic [3:0]            r_cnt, w_cnt;
  logic                  r_fv, r_fl, r_pend, w_fv, w_fl, w_pend;

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!iStall) begin
      case (r_state)
        S_RUN:   if (iBranchValid) begin
                   if (iFlagsBusy)        w_state_nxt = S_WAIT;
                   else if (iBranchTaken) w_state_nxt = S_FLUSH;
                 end
        S_WAIT:  if (!iFlagsBusy) w_state_nxt = iBranchTaken ? S_FLUSH : S_RUN;
        S_FLUSH: if (r_cnt <= 4'd1) w_state_nxt = S_RUN;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Next values of the registered outputs; a stall leaves every default (hold) in place.
  always_comb begin
    w_pc   = r_pc;
    w_tgt  = r_tgt;
    w_cnt  = r_cnt;
    w_fv   = r_fv;
    w_fl   = r_fl;
    w_pend = r_pend;
    if (!iStall) begin
      case (r_state)
        S_RUN: begin
          w_pc   = r_pc + ONE;
          w_fv   = 1'b1;
          w_fl   = 1'b0;
          w_pend = 1'b0;
          if (iBranchValid) begin
            if (iFlagsBusy) begin
              w_tgt  = iBranchTarget;
              w_pc   = r_pc;
              w_fv   = 1'b0;
              w_pend = 1'b1;
            end else if (iBranchTaken) begin
              w_pc  = iBranchTarget;
              w_fl  = 1'b1;
              w_cnt = FC;
            end
          end
        end
        S_WAIT: begin
          if (!iFlagsBusy) begin
            w_pend = 1'b0;
            w_fv   = 1'b1;
            if (iBranchTaken) begin
              w_pc  = r_tgt;
              w_fl  = 1'b1;
              w_cnt = FC;
            end else begin
              w_pc = r_pc + ONE;
            end
          end
        end
        S_FLUSH: begin
          w_pc = r_pc + ONE;
          w_fv = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_fl  = 1'b0;
            w_cnt = 4'd0;
          end else begin
            w_cnt = r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc   <= RST_PC;
      r_tgt  <= '0;
      r_cnt  <= 4'd0;
      r_fv   <= 1'b1;
      r_fl   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_pc   <= w_pc;
      r_tgt  <= w_tgt;
      r_cnt  <= w_cnt;
      r_fv   <= w_fv;
      r_fl   <= w_fl;
      r_pend <= w_pend;
    end
  end

  assign oPC            = r_pc;
  assign oFetchValid    = r_fv;
  assign oFlush         = r_fl;
  assign oBranchPending = r_pend;

`ifdef BRANCH_STATS_EN
  logic        w_resolve, w_taken;
  logic [15:0] r_bcnt, r_tcnt;

  // A branch resolves only where iBranchTaken is actually consumed.
  assign w_resolve = !iStall && !iFlagsBusy &&
                     ((r_state == S_RUN && iBranchValid) || r_state == S_WAIT);
  assign w_taken   = w_resolve && iBranchTaken;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_bcnt <= 16'd0;
      r_tcnt <= 16'd0;
    end else begin
      if (w_resolve && r_bcnt != 16'hFFFF) r_bcnt <= r_bcnt + 16'd1;
      if (w_taken   && r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
    end
  end

  assign oBranchCount = r_bcnt;
  assign oTakenCount  = r_tcnt;
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Scoreboard bench for branch_pc_sequencer: driver queues hand-computed expectations, monitor checks after each edge.
module tb_branch_pc_sequencer;

  logic       Clock = 1'b0;
  logic       Reset, iStall, iBranchValid, iBranchTaken, iFlagsBusy;
  logic [9:0] iBranchTarget;
  logic [9:0] oPC;
  logic       oFetchValid, oFlush, oBranchPending;
`ifdef BRANCH_STATS_EN
  logic [15:0] oBranchCount, oTakenCount;
`endif

  branch_pc_sequencer #(.ADDR_WIDTH(10), .RESET_PC(16), .FLUSH_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall),
    .iBranchValid(iBranchValid), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .iFlagsBusy(iFlagsBusy),
    .oPC(oPC), .oFetchValid(oFetchValid), .oFlush(oFlush), .oBranchPending(oBranchPending)
`ifdef BRANCH_STATS_EN
    , .oBranchCount(oBranchCount), .oTakenCount(oTakenCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         id;
    logic [9:0] pc;
    logic       fv, fl, pd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   step_id = 0;

  // Monitor: every edge after a driven step presents one registered output vector.
  always @(posedge Clock) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (oPC !== e.pc || oFetchValid !== e.fv || oFlush !== e.fl || oBranchPending !== e.pd) begin
        n_fail++;
        $display("FAIL step%0d: got pc=%h fv=%b fl=%b pd=%b, want pc=%h fv=%b fl=%b pd=%b",
                 e.id, oPC, oFetchValid, oFlush, oBranchPending, e.pc, e.fv, e.fl, e.pd);
      end
    end
  end

  task automatic step(input logic rst, input logic stall, input logic bv, input logic bt,
                      input logic [9:0] tgt, input logic busy,
                      input logic [9:0] epc, input logic efv, input logic efl, input logic epd);
    exp_t e;
    @(negedge Clock);
    Reset = rst; iStall = stall; iBranchValid = bv; iBranchTaken = bt;
    iBranchTarget = tgt; iFlagsBusy = busy;
    e.id = step_id; e.pc = epc; e.fv = efv; e.fl = efl; e.pd = epd;
    q.push_back(e);
    step_id++;
  endtask

  // Plain run cycle, no branch.
  task automatic run(input logic [9:0] epc, input logic efl);
    step(0, 0, 0, 0, 10'h000, 0, epc, 1, efl, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; iStall = 0; iBranchValid = 0; iBranchTaken = 0; iBranchTarget = '0; iFlagsBusy = 0;
    // reset state and sequential fetch
    step(1, 0, 0, 0, 10'h000, 0, 10'h010, 1, 0, 0);
    step(1, 0, 0, 0, 10'h000, 0, 10'h010, 1, 0, 0);
    run(10'h011, 0); run(10'h012, 0); run(10'h013, 0); run(10'h014, 0);
    // jump near the top, flush, then wrap
    step(0, 0, 1, 1, 10'h3FD, 0, 10'h3FD, 1, 1, 0);
    run(10'h3FE, 1);
    run(10'h3FF, 0);
    run(10'h000, 0);
    run(10'h001, 0);
    // direct taken branch
    step(0, 0, 1, 1, 10'h120, 0, 10'h120, 1, 1, 0);
    run(10'h121, 1);
    run(10'h122, 0);
    run(10'h123, 0);
    // wait on flags, then taken (re-presented target 0x2AA must be ignored)
    step(0, 0, 1, 0, 10'h050, 1, 10'h123, 0, 0, 1);
    step(0, 0, 1, 1, 10'h2AA, 1, 10'h123, 0, 0, 1);
    step(0, 0, 1, 1, 10'h2AA, 1, 10'h123, 0, 0, 1);
    step(0, 0, 1, 1, 10'h2AA, 0, 10'h050, 1, 1, 0);
    run(10'h051, 1);
    run(10'h052, 0);
    // wait on flags, then not taken
    step(0, 0, 1, 0, 10'h0F0, 1, 10'h052, 0, 0, 1);
    step(0, 0, 1, 0, 10'h0F0, 1, 10'h052, 0, 0, 1);
    step(0, 0, 1, 0, 10'h0F0, 1, 10'h052, 0, 0, 1);
    step(0, 0, 0, 0, 10'h0F0, 0, 10'h053, 1, 0, 0);
    run(10'h054, 0);
    // stall inside flush with a wrong-path branch presented
    step(0, 0, 1, 1, 10'h200, 0, 10'h200, 1, 1, 0);
    step(0, 1, 1, 1, 10'h3AA, 0, 10'h200, 1, 1, 0);
    step(0, 1, 1, 1, 10'h3AA, 0, 10'h200, 1, 1, 0);
    step(0, 0, 1, 1, 10'h3AA, 0, 10'h201, 1, 1, 0);
    run(10'h202, 0);
    run(10'h203, 0);
    // reset during WAIT_FLAGS
    step(0, 0, 1, 1, 10'h111, 1, 10'h203, 0, 0, 1);
    step(1, 0, 1, 1, 10'h111, 1, 10'h010, 1, 0, 0);
    run(10'h011, 0);
    // reset during FLUSH
    step(0, 0, 1, 1, 10'h100, 0, 10'h100, 1, 1, 0);
    step(1, 0, 0, 0, 10'h000, 0, 10'h010, 1, 0, 0);
    run(10'h011, 0);
    // 3 taken + 2 not-taken after reset
    step(0, 0, 1, 1, 10'h300, 0, 10'h300, 1, 1, 0);
    run(10'h301, 1);
    run(10'h302, 0);
    step(0, 0, 1, 0, 10'h155, 0, 10'h303, 1, 0, 0);
    step(0, 0, 1, 1, 10'h080, 1, 10'h303, 0, 0, 1);
    step(0, 0, 1, 1, 10'h080, 0, 10'h080, 1, 1, 0);
    run(10'h081, 1);
    run(10'h082, 0);
    step(0, 0, 1, 0, 10'h090, 1, 10'h082, 0, 0, 1);
    step(0, 0, 1, 0, 10'h090, 0, 10'h083, 1, 0, 0);
    step(0, 1, 1, 1, 10'h0A0, 0, 10'h083, 1, 0, 0);
    step(0, 0, 1, 1, 10'h0A0, 0, 10'h0A0, 1, 1, 0);
    run(10'h0A1, 1);
    run(10'h0A2, 0);

    // drain: every queued expectation must be consumed within a few edges
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clock);
    @(negedge Clock);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
`ifdef BRANCH_STATS_EN
    n_chk++;
    if (oBranchCount !== 16'd5) begin
      n_fail++;
      $display("FAIL branch_count: got %0d want 5", oBranchCount);
    end
    n_chk++;
    if (oTakenCount !== 16'd3) begin
      n_fail++;
      $display("FAIL taken_count: got %0d want 3", oTakenCount);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
